// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the sequential divider.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : alu_pkg

// File: rtl/divider_32bit_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface divider_32bit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface : divider_32bit_if

// File: rtl/divider_32bit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, select.
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Partial remainder stays below divisor, so the top bit of the difference is its sign.
    always_comb begin
        shifted_s = {rem_i[WIDTH-1:0], dvd_bit_i};
        diff_s    = shifted_s - {1'b0, divisor_i};
        if (diff_s[WIDTH] == 1'b0) begin
            rem_o   = diff_s;
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted_s;
            q_bit_o = 1'b0;
        end
    end

endmodule : div_step

// File: rtl/divider_32bit.sv
// Unsigned 32-cycle restoring divider with a divide-by-zero shortcut.
module divider_32bit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    divider_32bit_if.slave  bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     prem_q, prem_d;
    logic [WIDTH-1:0]   dq_q, dq_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     step_rem_s;
    logic               step_q_s;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (prem_q),
        .dvd_bit_i (dq_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_s),
        .q_bit_o   (step_q_s)
    );

    // dq_q shifts the dividend out of its MSB while quotient bits fill in from the LSB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    if (bus.divisor != {WIDTH{1'b0}}) begin
                        dvs_d   = bus.divisor;
                        dq_d    = bus.dividend;
                        prem_d  = {(WIDTH+1){1'b0}};
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = RUN;
                    end else begin
                        quot_d  = {WIDTH{1'b1}};
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                prem_d = step_rem_s;
                dq_d   = {dq_q[WIDTH-2:0], step_q_s};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    quot_d  = {dq_q[WIDTH-2:0], step_q_s};
                    rem_d   = step_rem_s[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            prem_q  <= {(WIDTH+1){1'b0}};
            dq_q    <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule : divider_32bit

// File: tb/tb_divider_32bit.sv
// Directed self-checking bench for divider_32bit.
module tb_divider_32bit;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    divider_32bit_if #(.WIDTH(32)) bus ();

    divider_32bit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation; optionally hold start high with other operands during lat in [nfrom, nto).
    task automatic run_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                          input int exp_lat, input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_dbz, input logic [31:0] prev_q,
                          input int nfrom, input int nto);
        int lat;
        int busy_cnt;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 32'hA5A5A5A5;
        bus.divisor  = 32'h5A5A5A5A;
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            if (lat == 16) check({tag, "_hold_q"}, bus.quotient, prev_q);
            bus.start = (lat >= nfrom && lat < nto);
            if (bus.start) begin
                bus.dividend = 32'd999;
                bus.divisor  = 32'd3;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({tag, "_done"},    32'(bus.done), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cyc"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, "_quot"},    bus.quotient, exp_q);
        check({tag, "_rem"},     bus.remainder, exp_r);
        check({tag, "_dbz"},     32'(bus.div_by_zero), 32'(exp_dbz));
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int lat;
        int gap;
        clk          = 1'b0;
        rst          = 1'b1;
        errors       = 0;
        checks       = 0;
        bus.start    = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_quot", bus.quotient, 32'd0);
        check("rst_rem",  bus.remainder, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dbz",  32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;

        run_op("d100_7",   32'd100,        32'd7,          32, 32'd14,         32'd2,          1'b0, 32'd0,          0, 0);
        run_op("dmax_1",   32'hFFFFFFFF,   32'd1,          32, 32'hFFFFFFFF,   32'd0,          1'b0, 32'd14,         0, 0);
        run_op("d1_max",   32'd1,          32'hFFFFFFFF,   32, 32'd0,          32'd1,          1'b0, 32'hFFFFFFFF,   0, 0);
        run_op("d0_noise", 32'd0,          32'h12345678,   32, 32'd0,          32'd0,          1'b0, 32'd0,          3, 20);
        run_op("d7_100",   32'd7,          32'd100,        32, 32'd0,          32'd7,          1'b0, 32'd0,          0, 0);
        run_op("d1000_10", 32'd1000,       32'd10,         32, 32'd100,        32'd0,          1'b0, 32'd0,          0, 0);
        run_op("dbz",      32'h12345678,   32'd0,          0,  32'hFFFFFFFF,   32'h12345678,   1'b1, 32'd100,        0, 0);

        // Reset in the middle of a 100/7 operation.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_quot",  bus.quotient, 32'd0);
        check("mrst_rem",   bus.remainder, 32'd0);
        check("mrst_busy",  32'(bus.busy), 32'd0);
        check("mrst_done",  32'(bus.done), 32'd0);
        check("mrst_dbz",   32'(bus.div_by_zero), 32'd0);
        check("mrst_state", 32'(dut.state_q), 32'(IDLE));

        run_op("dmax_2p28", 32'hFFFFFFFF, 32'h10000000, 32, 32'd15, 32'h0FFFFFFF, 1'b0, 32'd0, 0, 0);

        // Back-to-back with start held high.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        @(negedge clk);
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_lat", 32'(lat), 32'd32);
        check("b2b_q0", bus.quotient, 32'd10);
        check("b2b_r0", bus.remainder, 32'd0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            gap = 1;
            check("b2b_run_notdone", 32'(bus.done), 32'd0);
            while (!bus.done && gap < 100) begin
                @(negedge clk);
                gap++;
            end
            check("b2b_gap", 32'(gap), 32'd33);
            check("b2b_q",   bus.quotient, 32'd10);
            check("b2b_r",   bus.remainder, 32'd0);
        end
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b_end_done", 32'(bus.done), 32'd0);
        check("b2b_end_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_divider_32bit

// File: doc/divider_32bit.md
DIVIDER_32BIT -- requirements
Module: divider_32bit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; the block SHALL be verified only at 32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a division; sampled only when accepting (see REQ-010).
REQ-005 dividend  input  32  unsigned dividend; captured on the accepting edge.
REQ-006 divisor  input  32  unsigned divisor; captured on the accepting edge.
REQ-007 quotient  output  32  registered unsigned quotient; holds until the next result.
REQ-008 remainder  output  32  registered unsigned remainder; holds until the next result.
REQ-009 busy  output  1  high while in RUN; done  output  1  one-cycle result-valid pulse; div_by_zero  output  1  registered flag qualifying the last result.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE; start SHALL be accepted only in IDLE or DONE.
REQ-011 IDLE or DONE with start=1 and divisor!=0: capture operands, clear the partial remainder, set the iteration counter to 31, and go to RUN.
REQ-012 IDLE or DONE with start=1 and divisor==0: go directly to DONE on that edge.
- Load quotient=32'hFFFFFFFF, remainder=dividend, div_by_zero=1.
- done is therefore high in the cycle after the accepting edge.
REQ-013 RUN: perform one unsigned restoring step per edge, MSB first.
- Shift the next dividend bit into the 33-bit partial remainder.
- Trial-subtract the divisor; keep the difference and shift in quotient bit 1 if it is non-negative, else keep the shifted value and shift in 0.
REQ-014 RUN SHALL last exactly 32 edges.
- On the edge where the counter is 0: load quotient/remainder, clear div_by_zero, go to DONE.
- done is therefore high in the cycle that begins 32 edges after the accepting edge.
REQ-015 DONE SHALL last one cycle, then return to IDLE unless start is accepted per REQ-011/012; done SHALL be 1 only in DONE.
REQ-016 start during RUN SHALL be ignored; the operands of the operation in flight SHALL be unaffected.
REQ-017 quotient, remainder and div_by_zero SHALL change only on the edge entering DONE, or on reset.
REQ-018 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor != 0.
REQ-019 busy SHALL equal (state==RUN).

Reset
REQ-020 rst=1 SHALL, on the same edge and regardless of state (including mid-RUN), force:
- state=IDLE;
- quotient=0, remainder=0;
- busy=0, done=0, div_by_zero=0;
- counter=0, partial remainder=0.
REQ-021 rst SHALL take priority over start; no operation SHALL be accepted on an edge where rst=1.

Structure
REQ-022 A shared package alu_pkg SHALL hold:
- the WIDTH default constant (32);
- the FSM state enum (IDLE, RUN, DONE);
- the counter width constant (5).
REQ-023 One combinational sub-module div_step SHALL implement the shift/trial-subtract/select step of REQ-013.
REQ-024 divider_32bit SHALL instantiate div_step once and own all registers.

Verification
REQ-025 Pulse start with dividend=100, divisor=7 -> done exactly 32 cycles later; quotient=14, remainder=2, div_by_zero=0; busy high for 32 cycles.
REQ-026 dividend=32'hFFFFFFFF, divisor=1 -> quotient=32'hFFFFFFFF, remainder=0. dividend=1, divisor=32'hFFFFFFFF -> quotient=0, remainder=1.
REQ-027 dividend=32'h12345678, divisor=0 -> done 1 cycle after start; quotient=32'hFFFFFFFF, remainder=32'h12345678, div_by_zero=1; busy never high.
REQ-028 dividend=0, divisor=32'h12345678 -> quotient=0, remainder=0 after 32 cycles. A second start held high during RUN with other operands -> ignored, no extra done.
REQ-029 Assert rst at RUN cycle 10 of 100/7 -> next cycle all outputs 0 and state IDLE; a following 32'hFFFFFFFF/32'h10000000 -> quotient=15, remainder=32'h0FFFFFFF.
REQ-030 Back-to-back: start held high continuously with 50/5 -> a new operation is accepted in each DONE cycle; quotient=10, remainder=0 on every done pulse, spaced 33 cycles apart.
